// File: rtl/alu_seq.sv
// Handshaked ALU: one operation per valid/ready transaction, registered result and flags.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier on opcode 111.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             ill
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd2;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam int         CNT_W   = $clog2(WIDTH + 1);
`endif

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             carry;
    logic             ovf;
    logic             ill;
  } res_t;

  // Single-cycle ops; opcode 111 reaching here means no multiplier exists.
  function automatic res_t alu_eval(input logic [WIDTH-1:0] a_v,
                                    input logic [WIDTH-1:0] b_v,
                                    input logic [2:0]       op);
    res_t       r;
    logic [WIDTH:0] ext;
    r   = '0;
    ext = '0;
    case (op)
      3'b000: begin
        ext     = {1'b0, a_v} + {1'b0, b_v};
        r.y     = ext[WIDTH-1:0];
        r.carry = ext[WIDTH];
        r.ovf   = (a_v[WIDTH-1] == b_v[WIDTH-1]) && (ext[WIDTH-1] != a_v[WIDTH-1]);
      end
      3'b001: begin
        ext     = {1'b0, a_v} - {1'b0, b_v};
        r.y     = ext[WIDTH-1:0];
        r.carry = ext[WIDTH];
        r.ovf   = (a_v[WIDTH-1] != b_v[WIDTH-1]) && (ext[WIDTH-1] != a_v[WIDTH-1]);
      end
      3'b010: r.y = a_v & b_v;
      3'b011: r.y = a_v | b_v;
      3'b100: r.y = a_v ^ b_v;
      3'b101: begin
        r.y     = {a_v[WIDTH-2:0], 1'b0};
        r.carry = a_v[WIDTH-1];
      end
      3'b110: begin
        r.y     = {1'b0, a_v[WIDTH-1:1]};
        r.carry = a_v[0];
      end
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;
  res_t             res;
`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  always_comb begin
    res     = alu_eval(a, b, s);
    state_d = state_q;
    y_d     = y_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
`ifdef ALU_SEQ_MUL_EN
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
          if (s == 3'b111) begin
            state_d  = ST_BUSY;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CNT_W'(WIDTH);
          end else
`endif
          begin
            state_d = ST_DONE;
            y_d     = res.y;
            carry_d = res.carry;
            zero_d  = (res.y == '0);
            ovf_d   = res.ovf;
            ill_d   = res.ill;
          end
        end
      end
`ifdef ALU_SEQ_MUL_EN
      // One shift-add step per cycle; the last step publishes the product.
      ST_BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          y_d     = acc_step[WIDTH-1:0];
          carry_d = |acc_step[2*WIDTH-1:WIDTH];
          zero_d  = (acc_step[WIDTH-1:0] == '0);
          ovf_d   = 1'b0;
          ill_d   = 1'b0;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
`ifdef ALU_SEQ_MUL_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

`ifdef ALU_SEQ_MUL_EN
  // Multiplier datapath needs no reset: it is always loaded at accept.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    acc_q    <= acc_d;
    mplier_q <= mplier_d;
  end
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign y         = y_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign ill       = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=8; covers both ALU_SEQ_MUL_EN builds.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic [2:0] s;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       carry, zero, ovf, ill;

  int n_chk  = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .carry(carry), .zero(zero), .ovf(ovf), .ill(ill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, measure latency in edges (accept edge counts as 1), check result, release it.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic [2:0] ts, input int exp_lat, input logic [7:0] ey,
                        input logic ec, input logic ez, input logic eo, input logic ei);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    a = ta; b = tb; s = ts; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); s = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk($sformatf("%s.lat", tag), lat, exp_lat);
    chk($sformatf("%s.y", tag), y, ey);
    chk($sformatf("%s.carry", tag), carry, ec);
    chk($sformatf("%s.zero", tag), zero, ez);
    chk($sformatf("%s.ovf", tag), ovf, eo);
    chk($sformatf("%s.ill", tag), ill, ei);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk($sformatf("%s.ov_drop", tag), out_valid, 0);
    chk($sformatf("%s.ir_rise", tag), in_ready, 1);
  endtask

  logic [7:0] sweep_y [7] = '{8'd20, 8'd0, 8'd10, 8'd10, 8'd0, 8'd20, 8'd5};
  logic       sweep_z [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 8'd1; b = 8'd1; s = 3'b000; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst%0d.in_ready", i), in_ready, 1);
      chk($sformatf("rst%0d.out_valid", i), out_valid, 0);
    end
    rst = 1'b0; in_valid = 1'b0;
    chk("reset.y", y, 0);
    chk("reset.flags", {carry, zero, ovf, ill}, 0);
    tick();
    chk("idle.out_valid", out_valid, 0);

    for (int i = 0; i < 7; i++)
      run_op($sformatf("sweep%0d", i), 8'd10, 8'd10, 3'(i), 1, sweep_y[i], 1'b0, sweep_z[i], 1'b0, 1'b0);

    run_op("add_carry", 8'd200, 8'd100, 3'b000, 1, 8'd44, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("add_ovf", 8'd100, 8'd100, 3'b000, 1, 8'd200, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("sub_borrow", 8'd10, 8'd20, 3'b001, 1, 8'd246, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("shl_msb", 8'h81, 8'd0, 3'b101, 1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("shr_lsb", 8'h81, 8'd0, 3'b110, 1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef ALU_SEQ_MUL_EN
    run_op("mul_255", 8'd15, 8'd17, 3'b111, 9, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("mul_256", 8'd16, 8'd16, 3'b111, 9, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
`else
    run_op("ill_111", 8'd15, 8'd17, 3'b111, 1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
`endif
    run_op("after_ill", 8'd1, 8'd2, 3'b000, 1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Backpressure: result held, a new op offered meanwhile is never taken.
    a = 8'd3; b = 8'd4; s = 3'b000; in_valid = 1'b1;
    tick();
    a = 8'd50; b = 8'd60; s = 3'b011;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d.out_valid", i), out_valid, 1);
      chk($sformatf("bp%0d.in_ready", i), in_ready, 0);
      chk($sformatf("bp%0d.y", i), y, 7);
      chk($sformatf("bp%0d.flags", i), {carry, zero, ovf, ill}, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_release.out_valid", out_valid, 0);
    chk("bp_release.in_ready", in_ready, 1);
    chk("bp_release.y", y, 7);
    tick();
    chk("bp_noaccept.out_valid", out_valid, 0);

    // Reset while a result waits in DONE discards it.
    a = 8'd5; b = 8'd5; s = 3'b000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rst_done.pre_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_done.out_valid", out_valid, 0);
    chk("rst_done.in_ready", in_ready, 1);
    chk("rst_done.y", y, 0);

`ifdef ALU_SEQ_MUL_EN
    begin
      int seen;
      a = 8'd15; b = 8'd17; s = 3'b111; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mul.in_ready", in_ready, 1);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        if (out_valid) seen++;
        tick();
      end
      chk("rst_mul.no_valid", seen, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", n_chk, 0);
    $fatal(1, "timeout");
  end
endmodule
